// File: rtl/udc_pkg.sv
// Shared definitions for the up/down counter sweep controller.
package udc_pkg;
  localparam int UDC_WIDTH   = 8;
  localparam int UDC_SWEEP_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    DONE     = 2'd3
  } udc_state_e;
endpackage

// File: rtl/udc_sweep_ctrl_if.sv
// Host-side bundle of the sweep controller: configuration and start/stop in,
// count, direction, progress and result pulses out, plus the FSM state for debug.
interface udc_sweep_ctrl_if #(
  parameter int WIDTH   = udc_pkg::UDC_WIDTH,
  parameter int SWEEP_W = udc_pkg::UDC_SWEEP_W
);
  import udc_pkg::*;

  // Handshake: start is honoured only while busy=0 (and stop=0); stop only while
  // a sweep runs. done, aborted and cfg_err are single-cycle result pulses.
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   lo_lim;
  logic [WIDTH-1:0]   hi_lim;
  logic [SWEEP_W-1:0] n_sweeps;
  logic [WIDTH-1:0]   count;
  logic               up_down;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               cfg_err;
  logic [SWEEP_W-1:0] sweeps_done;
  udc_state_e         state;

  modport master (
    output start, stop, lo_lim, hi_lim, n_sweeps,
    input  count, up_down, busy, done, aborted, cfg_err, sweeps_done, state
  );

  modport slave (
    input  start, stop, lo_lim, hi_lim, n_sweeps,
    output count, up_down, busy, done, aborted, cfg_err, sweeps_done, state
  );
endinterface

// File: rtl/udc_core.sv
// WIDTH-bit up/down count register with synchronous load; load beats enable.
module udc_core #(
  parameter int WIDTH = udc_pkg::UDC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up_down ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: rtl/udc_sweep_ctrl.sv
// Sequences udc_core through triangular lo->hi->lo sweeps, n times or until stop.
module udc_sweep_ctrl
  import udc_pkg::*;
#(
  parameter int WIDTH   = UDC_WIDTH,
  parameter int SWEEP_W = UDC_SWEEP_W
) (
  input  logic           clk,
  input  logic           reset,
  udc_sweep_ctrl_if.slave bus
);
  udc_state_e         state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [SWEEP_W-1:0] n_q, n_d, sweeps_q, sweeps_d, sweeps_inc;
  logic               up_down_q, up_down_d;
  logic               busy_q, done_q, aborted_q, cfg_err_q;
  logic               done_d, aborted_d, cfg_err_d;
  logic               load, en, core_dir;
  logic [WIDTH-1:0]   load_val, count;

  assign sweeps_inc = sweeps_q + 1'b1;

  udc_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_down  (core_dir),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweeps_q  <= '0;
      up_down_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      n_q       <= n_d;
      sweeps_q  <= sweeps_d;
      up_down_q <= up_down_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    n_d       = n_q;
    sweeps_d  = sweeps_q;
    up_down_d = up_down_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    load_val  = count;
    en        = 1'b0;
    core_dir  = up_down_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.lo_lim >= bus.hi_lim) begin
            cfg_err_d = 1'b1;
          end else begin
            lo_d      = bus.lo_lim;
            hi_d      = bus.hi_lim;
            n_d       = bus.n_sweeps;
            sweeps_d  = '0;
            up_down_d = 1'b1;
            load      = 1'b1;
            load_val  = bus.lo_lim;
            state_d   = RUN_UP;
          end
        end
      end
      RUN_UP: begin
        if (bus.stop) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (count != hi_q) begin
          en       = 1'b1;
          core_dir = 1'b1;
        end else begin
          load      = 1'b1;
          load_val  = hi_q - 1'b1;
          up_down_d = 1'b0;
          state_d   = RUN_DOWN;
        end
      end
      RUN_DOWN: begin
        // A round trip that finishes on the stop cycle is still counted.
        if (count == lo_q) begin
          sweeps_d = sweeps_inc;
        end
        if (bus.stop) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (count != lo_q) begin
          en       = 1'b1;
          core_dir = 1'b0;
        end else if ((n_q != '0) && (sweeps_inc == n_q)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          load      = 1'b1;
          load_val  = lo_q + 1'b1;
          up_down_d = 1'b1;
          state_d   = RUN_UP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.count       = count;
  assign bus.up_down     = up_down_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.sweeps_done = sweeps_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_udc_sweep_ctrl.sv
// Directed bench for udc_sweep_ctrl: driver pushes the expected post-edge output
// snapshot per cycle; a negedge monitor pops and compares it.
module tb_udc_sweep_ctrl;
  import udc_pkg::*;

  localparam int W  = 21;

  logic clk = 1'b0;
  logic reset;
  udc_sweep_ctrl_if #(.WIDTH(8), .SWEEP_W(8)) bus ();

  udc_sweep_ctrl #(.WIDTH(8), .SWEEP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Snapshot: {count, up_down, busy, done, aborted, cfg_err, sweeps_done}
  function automatic logic [W-1:0] e(input int cnt, input bit ud, input bit busy,
                                     input bit dn, input bit ab, input bit cfg,
                                     input int sw);
    logic [7:0] c8, s8;
    c8 = cnt[7:0];
    s8 = sw[7:0];
    return {c8, ud, busy, dn, ab, cfg, s8};
  endfunction

  task automatic step(input bit s, input bit p, input bit r, input logic [W-1:0] x);
    bus.start = s;
    bus.stop  = p;
    reset     = r;
    @(posedge clk);
    #1;
    exp_q.push_back(x);
  endtask

  task automatic set_cfg(input int lo, input int hi, input int n);
    bus.lo_lim   = lo[7:0];
    bus.hi_lim   = hi[7:0];
    bus.n_sweeps = n[7:0];
  endtask

  always @(negedge clk) begin
    logic [W-1:0] got, x;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      got = {bus.count, bus.up_down, bus.busy, bus.done, bus.aborted, bus.cfg_err,
             bus.sweeps_done};
      n_vec++;
      if (got !== x) begin
        n_err++;
        $display("FAIL vec%0d t=%0t: got cnt=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b sw=%0d, want cnt=%0d ud=%0b busy=%0b done=%0b ab=%0b cfg=%0b sw=%0d",
                 n_vec, $time, got[20:13], got[12], got[11], got[10], got[9], got[8],
                 got[7:0], x[20:13], x[12], x[11], x[10], x[9], x[8], x[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  int mc [13] = '{10, 11, 12, 11, 10, 11, 12, 11, 10, 11, 12, 11, 10};
  bit md [13] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
  int ms [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    reset     = 1'b1;
    set_cfg(0, 0, 0);

    // Reset state
    step(0, 0, 1, e(0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 1, e(0, 0, 0, 0, 0, 0, 0));

    // Reset mid-run at count=4 in RUN_UP
    set_cfg(2, 5, 1);
    step(1, 0, 0, e(2, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(3, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(4, 1, 1, 0, 0, 0, 0));
    step(0, 0, 1, e(0, 0, 0, 0, 0, 0, 0));
    step(0, 0, 0, e(0, 0, 0, 0, 0, 0, 0));

    // Single sweep 2..5..2
    step(1, 0, 0, e(2, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(3, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(4, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(5, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(4, 0, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(3, 0, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(2, 0, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(2, 0, 1, 1, 0, 0, 1));
    step(0, 0, 0, e(2, 0, 0, 0, 0, 0, 1));

    // Rejected configurations: lo == hi, then lo > hi
    set_cfg(7, 7, 1);
    step(1, 0, 0, e(2, 0, 0, 0, 0, 1, 1));
    step(0, 0, 0, e(2, 0, 0, 0, 0, 0, 1));
    set_cfg(9, 3, 1);
    step(1, 0, 0, e(2, 0, 0, 0, 0, 1, 1));
    step(0, 0, 0, e(2, 0, 0, 0, 0, 0, 1));

    // Three sweeps 10..12..10; start and new limits mid-run must be ignored
    set_cfg(10, 12, 3);
    step(1, 0, 0, e(mc[0], md[0], 1, 0, 0, 0, ms[0]));
    for (int i = 1; i < 13; i++) begin
      if (i == 3) set_cfg(0, 200, 1);
      step(i == 3, 0, 0, e(mc[i], md[i], 1, 0, 0, 0, ms[i]));
    end
    step(0, 0, 0, e(10, 0, 1, 1, 0, 0, 3));
    step(0, 0, 0, e(10, 0, 0, 0, 0, 0, 3));

    // Continuous run 0..255 aborted at count=100
    set_cfg(0, 255, 0);
    step(1, 0, 0, e(0, 1, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 100; i++) begin
      step(0, 0, 0, e(i, 1, 1, 0, 0, 0, 0));
    end
    step(0, 1, 0, e(100, 1, 0, 0, 1, 0, 0));
    step(0, 0, 0, e(100, 1, 0, 0, 0, 0, 0));
    // start together with stop in IDLE does nothing
    step(1, 1, 0, e(100, 1, 0, 0, 0, 0, 0));
    step(0, 0, 0, e(100, 1, 0, 0, 0, 0, 0));

    // Stop on the final-sweep edge: stop wins, trip still counted
    set_cfg(4, 6, 1);
    step(1, 0, 0, e(4, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(5, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(6, 1, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(5, 0, 1, 0, 0, 0, 0));
    step(0, 0, 0, e(4, 0, 1, 0, 0, 0, 0));
    step(0, 1, 0, e(4, 0, 0, 0, 1, 0, 1));
    step(0, 0, 0, e(4, 0, 0, 0, 0, 0, 1));

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected snapshots never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
